// File: rtl/spi_pwm_config.sv
// Write-only SPI (mode 0, MSB first) target holding the five 8-bit pwm_peripheral config registers.
// Frame = {rw, addr[6:0], data[7:0]}; only exact 16-bit writes to a valid address take effect.
module spi_pwm_config #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sr, copi_sr, ncs_sr;
  logic                   sclk_prev, ncs_prev;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;
  logic                   fall_hold, start;
  logic [4:0]             bit_cnt;
  logic [15:0]            shift_reg;
  logic [6:0]             addr;
  logic                   wr_ok;
  state_t                 state, state_n;

  // ncs chain resets high so releasing reset never fakes a chip-select edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr   <= '0;
      copi_sr   <= '0;
      ncs_sr    <= '1;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      copi_sr   <= {copi_sr[SYNC_STAGES-2:0], copi};
      ncs_sr    <= {ncs_sr[SYNC_STAGES-2:0], ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign copi_s    = copi_sr[SYNC_STAGES-1];
  assign ncs_s     = ncs_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  // a fall seen while committing is remembered for one cycle so back-to-back frames survive
  assign start = ncs_fall | fall_hold;
  assign addr  = shift_reg[14:8];
  assign wr_ok = (bit_cnt == 5'd16) && shift_reg[15] && (addr <= MAX_A);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (ncs_rise) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      fall_hold       <= 1'b0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      cfg_update      <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      state      <= state_n;
      fall_hold  <= (state == COMMIT) && ncs_fall;
      cfg_update <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            // saturating at 17 keeps over-long frames distinguishable from exact ones
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (wr_ok) begin
            cfg_update <= 1'b1;
            case (addr)
              7'd0:    en_reg_out_7_0  <= shift_reg[7:0];
              7'd1:    en_reg_out_15_8 <= shift_reg[7:0];
              7'd2:    en_reg_pwm_7_0  <= shift_reg[7:0];
              7'd3:    en_reg_pwm_15_8 <= shift_reg[7:0];
              7'd4:    pwm_duty_cycle  <= shift_reg[7:0];
              default: cfg_update      <= 1'b0;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: stimulus pushes expected register images and pulse times into a
// scoreboard; a monitor pops and compares on every cfg_update pulse.
module tb_spi_pwm_config;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       cfg_update;

  spi_pwm_config #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [39:0] regs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m[0:4];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(posedge clk) cyc++;

  function automatic logic [39:0] dut_vec();
    return {r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [39:0] mvec();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every pulse must match the oldest outstanding write, in time and in content
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cfg_update !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got cfg_update=%b at cycle %0d expected no pulse", cfg_update, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("pulse_regs", {24'h0, dut_vec()}, {24'h0, e.regs});
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      clocks(4);
      sclk = 1'b1;
      clocks(4);
      sclk = 1'b0;
    end
  endtask

  // wr marks a frame the hand analysis says must be accepted; the model then expects its pulse
  task automatic send_frame(input logic [16:0] bits, input int n, input bit wr, input int gap);
    exp_t e;
    ncs = 1'b0;
    clocks(4);
    send_bits(bits, n);
    clocks(4);
    ncs = 1'b1;
    if (wr) begin
      m[bits[14:8]] = bits[7:0];
      e.cyc  = cyc + SYNC + 2;
      e.regs = mvec();
      sb.push_back(e);
    end
    clocks(gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_hold(input string name);
    clocks(10);
    chk(name, {24'h0, dut_vec()}, {24'h0, mvec()});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    clocks(3);
    chk("reset_regs", {24'h0, dut_vec()}, 64'h0);
    chk("reset_update", 64'(cfg_update), 64'd0);
    rst_n = 1'b1;
    clocks(5);

    // give reset something to clear, then kill a frame after 8 bits
    send_frame(17'h08155, 16, 1'b1, 10);
    drain("drain_pre_reset");
    ncs = 1'b0;
    clocks(4);
    send_bits(17'h00084, 8);
    rst_n = 1'b0;
    ncs = 1'b1;
    clocks(3);
    chk("midframe_reset_regs", {24'h0, dut_vec()}, 64'h0);
    chk("midframe_reset_update", 64'(cfg_update), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    clocks(10);
    chk("post_reset_regs", {24'h0, dut_vec()}, 64'h0);

    // one write per address
    send_frame(17'h080F0, 16, 1'b1, 10);
    send_frame(17'h0810F, 16, 1'b1, 10);
    send_frame(17'h082AA, 16, 1'b1, 10);
    send_frame(17'h08355, 16, 1'b1, 10);
    send_frame(17'h08480, 16, 1'b1, 10);
    drain("drain_writes");
    chk("all_regs", {24'h0, dut_vec()}, 64'h80_55_AA_0F_F0);

    // read frame and out-of-range address
    send_frame(17'h00012, 16, 1'b0, 10);
    send_frame(17'h085FF, 16, 1'b0, 10);
    chk_hold("hold_read_badaddr");

    // 15 bits (top of 0x8033) and 17 bits are both dropped
    send_frame(17'h04019, 15, 1'b0, 10);
    send_frame(17'h102AB, 17, 1'b0, 10);
    chk_hold("hold_bad_length");

    // back-to-back with ncs high only SYNC+1 clocks
    send_frame(17'h08411, 16, 1'b1, SYNC + 1);
    send_frame(17'h08422, 16, 1'b1, 10);
    drain("drain_b2b");
    chk("b2b_duty", 64'(r4), 64'h22);

    // sclk noise with ncs high, then one valid write
    for (int i = 0; i < 5; i++) begin
      copi = 1'(i);
      sclk = 1'b1;
      clocks(4);
      sclk = 1'b0;
      clocks(4);
    end
    chk_hold("hold_noise");
    send_frame(17'h08001, 16, 1'b1, 10);
    drain("drain_noise");
    chk("noise_regs", {24'h0, dut_vec()}, 64'h22_55_AA_0F_01);

    clocks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
